// File: rtl/multiword_add_seq_pkg.sv
// Shared types and constants for the multiword add/subtract sequencer.
package multiword_add_seq_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/multiword_add_seq_add32.sv
// 32-bit carry-skip adder: 4-bit ripple blocks whose carry bypasses a block when all bits propagate.
module carry_skip_add32
    import multiword_add_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    localparam int BLK_W = 4;
    localparam int N_BLK = WORD_W / BLK_W;

    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] g;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        logic c_blk;
        logic c_rip;
        sum   = '0;
        c_blk = cin;
        c_rip = cin;
        for (int k = 0; k < N_BLK; k++) begin
            c_rip = c_blk;
            for (int j = 0; j < BLK_W; j++) begin
                sum[k*BLK_W+j] = p[k*BLK_W+j] ^ c_rip;
                c_rip          = g[k*BLK_W+j] | (p[k*BLK_W+j] & c_rip);
            end
            // A fully propagating block passes its incoming carry straight through.
            c_blk = (&p[k*BLK_W +: BLK_W]) ? c_blk : c_rip;
        end
        cout = c_blk;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Streams multiword A+B or A-B one 32-bit word per beat, LS word first.
// Define MWADD_OVF_EN to generate signed-overflow detection on the last beat.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int MAX_BEATS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_carry,
    output logic              out_ovf,
    output logic              err
);

    localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

    state_e            state_q;
    logic              carry_q;
    logic              mode_q;
    logic [7:0]        cnt_q;
    logic              out_valid_q;
    logic [WORD_W-1:0] sum_q;
    logic              last_q;
    logic              carry_out_q;
    logic              err_q;

    logic              accept, proc, drop;
    logic              mode_d, cin_d, force_d, last_d, err_set;
    logic [WORD_W-1:0] b_d, sum_d;
    logic              cout_d;
    logic [7:0]        cnt_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // Mid-packet beats are always processed; in IDLE only a first beat is.
    assign proc     = accept && (in_first || state_q == BUSY);
    assign drop     = accept && !in_first && state_q == IDLE;

    assign mode_d  = in_first ? in_sub : mode_q;
    assign cin_d   = in_first ? in_sub : carry_q;
    assign b_d     = mode_d ? ~in_b : in_b;
    assign cnt_d   = in_first ? 8'd1 : cnt_q + 8'd1;
    assign force_d = (cnt_d == MAX_B) && !in_last;
    assign last_d  = in_last || force_d;
    assign err_set = drop || (proc && ((in_first && state_q == BUSY) || force_d));

    carry_skip_add32 u_add (
        .a    (in_a),
        .b    (b_d),
        .cin  (cin_d),
        .sum  (sum_d),
        .cout (cout_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            last_q      <= 1'b0;
            carry_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (err_set) err_q <= 1'b1;
            if (proc) begin
                state_q     <= last_d ? IDLE : BUSY;
                carry_q     <= cout_d;
                mode_q      <= mode_d;
                cnt_q       <= last_d ? 8'd0 : cnt_d;
                out_valid_q <= 1'b1;
                sum_q       <= sum_d;
                last_q      <= last_d;
                carry_out_q <= last_d ? cout_d : 1'b0;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef MWADD_OVF_EN
    logic ovf_q;
    logic ovf_d;

    assign ovf_d = last_d && (in_a[WORD_W-1] == b_d[WORD_W-1]) && (sum_d[WORD_W-1] != in_a[WORD_W-1]);

    always_ff @(posedge clk) begin
        if (rst)       ovf_q <= 1'b0;
        else if (proc) ovf_q <= ovf_d;
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_last  = last_q;
    assign out_carry = carry_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed and randomized bench for multiword_add_seq; a second instance uses MAX_BEATS=2.
module tb_multiword_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_a, in_b;
    logic        in_first, in_last, in_sub;
    logic        out_ready;

    logic        in_ready, out_valid, out_last, out_carry, out_ovf, err;
    logic [31:0] out_sum;
    logic        in_ready2, out_valid2, out_last2, out_carry2, out_ovf2, err2;
    logic [31:0] out_sum2;

    int checks = 0;
    int errors = 0;

`ifdef MWADD_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    multiword_add_seq #(.MAX_BEATS(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last),
        .out_carry(out_carry), .out_ovf(out_ovf), .err(err)
    );

    multiword_add_seq #(.MAX_BEATS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
        .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2), .out_last(out_last2),
        .out_carry(out_carry2), .out_ovf(out_ovf2), .err(err2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offers one beat from a falling edge and returns 1 ns after the accepting rising edge.
    task automatic beat(input logic [31:0] a, input logic [31:0] b,
                        input logic first, input logic last, input logic sub);
        int waited;
        @(negedge clk);
        in_a = a; in_b = b; in_first = first; in_last = last; in_sub = sub;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) chk("accept_timeout", 64'(waited), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [263:0] ra, rb, rr, mask;
        logic [31:0]  exp_w;
        logic         exp_c, exp_v, sa, sb, sr;
        int           n;
        logic         sub;
        logic [31:0]  held;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_flags", {out_last, out_carry, out_ovf, err}, 4'b0000);
        chk("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // Two-word add with carry rippling across the word boundary.
        beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        chk("add2_w0_valid", out_valid, 1'b1);
        chk("add2_w0_sum", out_sum, 32'h0);
        chk("add2_w0_last_carry", {out_last, out_carry}, 2'b00);
        beat(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        chk("add2_w1_sum", out_sum, 32'h0);
        chk("add2_w1_last_carry", {out_last, out_carry}, 2'b11);
        @(posedge clk); #1;
        chk("add2_valid_falls", out_valid, 1'b0);

        // Single-word subtracts.
        beat(32'd5, 32'd7, 1'b1, 1'b1, 1'b1);
        chk("sub1_sum", out_sum, 32'hFFFF_FFFE);
        chk("sub1_carry", {out_last, out_carry, out_ovf}, 3'b100);
        beat(32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b1);
        chk("subovf_sum", out_sum, 32'h7FFF_FFFF);
        chk("subovf_carry", out_carry, 1'b1);
        chk("subovf_ovf", out_ovf, OVF_EN);

        // Backpressure in the middle of a packet.
        beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        chk("bp_w0_sum", out_sum, 32'hFFFF_FFFE);
        held = out_sum;
        @(negedge clk);
        out_ready = 1'b0;
        in_a = 32'h0; in_b = 32'h0; in_first = 1'b0; in_last = 1'b1; in_sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_hold", {out_valid, out_sum, out_last}, {1'b1, held, 1'b0});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_w1_sum", out_sum, 32'h1);
        chk("bp_w1_last_carry", {out_valid, out_last, out_carry}, 3'b110);

        // Non-first beat while idle is dropped and latches err.
        chk("err_before", err, 1'b0);
        beat(32'd3, 32'd4, 1'b0, 1'b1, 1'b0);
        chk("drop_no_valid", out_valid, 1'b0);
        chk("drop_err", err, 1'b1);
        beat(32'd3, 32'd4, 1'b1, 1'b1, 1'b0);
        chk("err_sticky_sum", out_sum, 32'd7);
        chk("err_sticky", err, 1'b1);
        do_reset();
        chk("err_cleared", err, 1'b0);

        // Three-beat packet: second instance forces the 2nd beat last and drops the 3rd.
        beat(32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
        chk("mb_w0", {out_valid2, out_sum2, out_last2, err2}, {1'b1, 32'd2, 1'b0, 1'b0});
        beat(32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        chk("mb_w1", {out_valid2, out_sum2, out_last2, err2}, {1'b1, 32'd4, 1'b1, 1'b1});
        beat(32'd3, 32'd3, 1'b0, 1'b1, 1'b0);
        chk("mb_w2_dropped", {out_valid2, err2}, 2'b01);
        chk("mb_wide_w2", {out_valid, out_sum, out_last, err}, {1'b1, 32'd6, 1'b1, 1'b0});

        // Reset mid-packet discards the pending carry.
        beat(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0);
        do_reset();
        chk("rstmid_zero", {out_valid, out_sum, out_last, out_carry, err}, 36'h0);
        beat(32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
        chk("rstmid_new_sum", out_sum, 32'd2);
        chk("rstmid_new_carry", {out_last, out_carry}, 2'b10);
        do_reset();

        // Random packets against a wide-integer reference.
        for (int p = 0; p < 25; p++) begin
            n    = int'($urandom_range(1, 8));
            sub  = 1'($urandom_range(0, 1));
            ra   = '0;
            rb   = '0;
            for (int i = 0; i < n; i++) begin
                ra[32*i +: 32] = $urandom;
                rb[32*i +: 32] = $urandom;
            end
            mask = (264'd1 << (32*n)) - 264'd1;
            if (sub) begin
                rr    = (ra - rb) & mask;
                exp_c = (ra >= rb);
            end else begin
                rr    = ra + rb;
                exp_c = rr[32*n];
            end
            sa = ra[32*n-1];
            sb = rb[32*n-1];
            sr = rr[32*n-1];
            exp_v = OVF_EN && (sub ? (sa != sb) : (sa == sb)) && (sr != sa);
            for (int i = 0; i < n; i++) begin
                beat(ra[32*i +: 32], rb[32*i +: 32], i == 0, i == n - 1, sub);
                exp_w = rr[32*i +: 32];
                chk("rnd_word", {out_valid, out_sum}, {1'b1, exp_w});
                chk("rnd_flags", {out_last, out_carry, out_ovf},
                    {i == n - 1, (i == n - 1) && exp_c, (i == n - 1) && exp_v});
            end
        end
        chk("rnd_err", err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 The block SHALL have parameter MAX_BEATS, default 8, meaning the maximum number of 32-bit beats in one operand packet (range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning an input beat is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts the beat this cycle.
REQ-006 The block SHALL have ports in_a and in_b, input, 32 each, carrying operand words, least-significant word first.
REQ-007 The block SHALL have ports in_first and in_last, input, 1 each, marking packet boundaries.
REQ-008 The block SHALL have port in_sub, input, 1, selecting A-B when sampled on a first beat; ignored on other beats.
REQ-009 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-010 The block SHALL have ports out_sum (output, 32), out_last (output, 1), and out_carry (output, 1; final carry/borrow-not, valid only when out_last=1, else 0).
REQ-011 The block SHALL have ports out_ovf (output, 1; signed overflow on the last beat) and err (output, 1; sticky protocol error).

Function
REQ-012 A beat SHALL be accepted when in_valid && in_ready; in_ready = !out_valid || out_ready, combinationally.
REQ-013 The block SHALL have FSM states IDLE (awaiting first beat) and BUSY (mid-packet).
REQ-014 In IDLE, an accepted beat with in_first=1 SHALL load op mode from in_sub; carry-in = in_sub; B operand = in_sub ? ~in_b : in_b.
REQ-015 In IDLE, an accepted beat with in_first=0 SHALL be dropped, produce no output, and set err.
REQ-016 In BUSY, carry-in SHALL be the carry register; B is inverted per the latched mode.
REQ-017 In BUSY, a beat with in_first=1 SHALL set err, then be processed as a new packet's first beat.
REQ-018 Each processed beat SHALL register out_sum = A + B' + cin (mod 2^32) and out_last = in_last; out_valid rises the cycle after acceptance (latency 1).
REQ-019 The carry register SHALL update only on accepted beats; when out_valid && !out_ready, all outputs hold stable.
REQ-020 Transitions: IDLE->BUSY on a processed first beat with in_last=0; any->IDLE on a processed beat with in_last=1; first&&last together is a one-word packet that stays in IDLE.
REQ-021 A beat counter SHALL count processed beats per packet; if the beat count reaches MAX_BEATS without in_last, that beat SHALL be forced last: out_last=1, err set, FSM->IDLE.
REQ-022 out_valid SHALL fall after a handshake with no new beat accepted in the same cycle; simultaneous output handshake and input accept SHALL yield back-to-back output.

Reset
REQ-023 On rst, the block SHALL set FSM=IDLE, carry=0, counter=0, mode=0, and outputs out_valid=0, out_sum=0, out_last=0, out_carry=0, out_ovf=0, err=0.
REQ-024 Reset mid-packet SHALL discard the partial packet; the next beat must carry in_first.

Configuration
REQ-025 With macro MWADD_OVF_EN defined, out_ovf SHALL be (A[31]==B'[31]) && (sum[31]!=A[31]) on the last beat, 0 otherwise; without it, out_ovf SHALL be tied 0 and no logic generated.

Structure
REQ-026 A shared package SHALL hold the FSM state enum and the word width constant (32).
REQ-027 The 32-bit add SHALL be a sub-module carry_skip_add32 (a, b, cin -> sum, cout), combinational, instantiated once.

Verification
REQ-028 2-beat add: (0xFFFFFFFF,0x00000001,first), (0xFFFFFFFF,0x00000000,last) -> sums 0x00000000, 0x00000000; out_carry=1.
REQ-029 1-beat sub: first&last, in_sub=1, A=5, B=7 -> out_sum=0xFFFFFFFE, out_carry=0; with MWADD_OVF_EN, A=0x80000000, B=1 -> out_ovf=1.
REQ-030 Backpressure: hold out_ready=0 for 3 cycles mid-packet -> in_ready=0, out_sum stable, carry chain correct after release.
REQ-031 Beat without in_first in IDLE -> no out_valid, err=1 and stays 1 until rst.
REQ-032 MAX_BEATS=2, 3-beat packet -> 2nd output has out_last=1, err=1; 3rd beat (no first) dropped.
REQ-033 rst asserted after first beat of 3 -> outputs zeroed; new packet (1+1, first&last) -> out_sum=2, carry from old packet not used.
